execute: RTL

Execute stage sitting directly downstream of decode/igen/control in the pd-series core. Holds the 32-entry integer register file, selects ALU operands, computes the ALU result and branch/jump resolution, and captures everything into a single output pipeline register toward memory/writeback. Upstream and downstream links use valid/ready handshakes; the register file write port is driven by writeback.

---
 rtl/pd_pkg.sv | 36 +++
 rtl/execute_if.sv | 38 +++
 rtl/register_file.sv | 23 ++
 rtl/execute.sv | 79 +++++++
 4 files changed

// File: rtl/pd_pkg.sv
// pd_pkg: shared ALU, opcode, branch and writeback encodings for the pd-series core
package pd_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_sel_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;
endpackage

// File: rtl/execute_if.sv
// execute_if: decode-side, writeback-side and memory-side links of the execute stage
interface execute_if #(parameter int DWIDTH = 32, parameter int AWIDTH = 32);
  logic              valid_i, ready_o;
  logic [AWIDTH-1:0] pc_i;
  logic [6:0]        opcode_i;
  logic [2:0]        funct3_i;
  logic [4:0]        rd_i, rs1_i, rs2_i;
  logic [DWIDTH-1:0] imm_i;
  logic              regwren_i, rs1sel_i, rs2sel_i, memren_i, memwren_i;
  logic [1:0]        wbsel_i;
  logic [3:0]        alusel_i;
  logic              wb_en_i;
  logic [4:0]        wb_rd_i;
  logic [DWIDTH-1:0] wb_data_i;
  logic              valid_o, ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] alu_res_o, rs2_data_o;
  logic [4:0]        rd_o;
  logic [2:0]        funct3_o;
  logic              regwren_o, memren_o, memwren_o;
  logic [1:0]        wbsel_o;
  logic              br_taken_o;
  logic [AWIDTH-1:0] br_target_o;
  modport slave (
    input  valid_i, pc_i, opcode_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i,
           regwren_i, rs1sel_i, rs2sel_i, memren_i, memwren_i, wbsel_i, alusel_i,
           wb_en_i, wb_rd_i, wb_data_i, ready_i,
    output ready_o, valid_o, pc_o, alu_res_o, rs2_data_o, rd_o, funct3_o,
           regwren_o, memren_o, memwren_o, wbsel_o, br_taken_o, br_target_o
  );
  modport master (
    output valid_i, pc_i, opcode_i, funct3_i, rd_i, rs1_i, rs2_i, imm_i,
           regwren_i, rs1sel_i, rs2sel_i, memren_i, memwren_i, wbsel_i, alusel_i,
           wb_en_i, wb_rd_i, wb_data_i, ready_i,
    input  ready_o, valid_o, pc_o, alu_res_o, rs2_data_o, rd_o, funct3_o,
           regwren_o, memren_o, memwren_o, wbsel_o, br_taken_o, br_target_o
  );
endinterface

// File: rtl/register_file.sv
// register_file: 32 x DWIDTH integer registers, two async reads with write-through bypass
module register_file #(parameter int DWIDTH = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic [DWIDTH-1:0] rs1_data,
  output logic [DWIDTH-1:0] rs2_data,
  input  logic              wen,
  input  logic [4:0]        wrd,
  input  logic [DWIDTH-1:0] wdata
);
  logic [DWIDTH-1:0] regs [32];
  logic              we;
  assign we = rst && wen && wrd != 5'd0;
  always_ff @(posedge clk)
    if (!rst)
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (we)
      regs[wrd] <= wdata;
  assign rs1_data = rs1 == 5'd0 ? '0 : (we && wrd == rs1) ? wdata : regs[rs1];
  assign rs2_data = rs2 == 5'd0 ? '0 : (we && wrd == rs2) ? wdata : regs[rs2];
endmodule

// File: rtl/execute.sv
// execute: operand select, ALU, branch/jump resolution and the output pipeline register
module execute import pd_pkg::*; #(parameter int DWIDTH = 32, parameter int AWIDTH = 32) (
  input logic       clk,
  input logic       rst,
  execute_if.slave  bus
);
  logic [DWIDTH-1:0] rs1_data, rs2_data, op_a, op_b, alu_res;
  logic [AWIDTH-1:0] pc_imm, jalr_tgt, target;
  logic              cmp, taken, is_br, is_jal, is_jalr;
  register_file #(.DWIDTH(DWIDTH)) u_rf (
    .clk(clk), .rst(rst), .rs1(bus.rs1_i), .rs2(bus.rs2_i),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wen(bus.wb_en_i), .wrd(bus.wb_rd_i), .wdata(bus.wb_data_i)
  );
  assign bus.ready_o = !bus.valid_o || bus.ready_i;
  assign op_a = bus.rs1sel_i ? DWIDTH'(bus.pc_i) : rs1_data;
  assign op_b = bus.rs2sel_i ? bus.imm_i : rs2_data;
  always_comb begin
    alu_res = '0;
    case (bus.alusel_i)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLL:   alu_res = op_a << op_b[4:0];
      ALU_SLT:   alu_res = DWIDTH'($signed(op_a) < $signed(op_b));
      ALU_SLTU:  alu_res = DWIDTH'(op_a < op_b);
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SRL:   alu_res = op_a >> op_b[4:0];
      ALU_SRA:   alu_res = DWIDTH'($signed(op_a) >>> op_b[4:0]);
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end
  assign is_br   = bus.opcode_i == OPC_BRANCH;
  assign is_jal  = bus.opcode_i == OPC_JAL;
  assign is_jalr = bus.opcode_i == OPC_JALR;
  // Branch comparison always uses raw register values, never the selected ALU operands
  assign cmp = bus.funct3_i == F3_BEQ  ? rs1_data == rs2_data :
               bus.funct3_i == F3_BNE  ? rs1_data != rs2_data :
               bus.funct3_i == F3_BLT  ? $signed(rs1_data) <  $signed(rs2_data) :
               bus.funct3_i == F3_BGE  ? $signed(rs1_data) >= $signed(rs2_data) :
               bus.funct3_i == F3_BLTU ? rs1_data <  rs2_data :
               bus.funct3_i == F3_BGEU ? rs1_data >= rs2_data : 1'b0;
  assign taken    = is_br ? cmp : (is_jal || is_jalr);
  assign pc_imm   = bus.pc_i + AWIDTH'(bus.imm_i);
  assign jalr_tgt = AWIDTH'(rs1_data + bus.imm_i) & ~AWIDTH'(1);
  assign target   = is_jalr ? jalr_tgt : (is_br || is_jal) ? pc_imm : '0;
  always_ff @(posedge clk)
    if (!rst) begin
      bus.valid_o     <= 1'b0;
      bus.br_taken_o  <= 1'b0;
      bus.br_target_o <= '0;
      bus.pc_o        <= '0;
      bus.alu_res_o   <= '0;
      bus.rs2_data_o  <= '0;
      bus.rd_o        <= '0;
      bus.funct3_o    <= '0;
      bus.regwren_o   <= 1'b0;
      bus.memren_o    <= 1'b0;
      bus.memwren_o   <= 1'b0;
      bus.wbsel_o     <= '0;
    end else if (bus.ready_o) begin
      bus.valid_o    <= bus.valid_i;
      bus.br_taken_o <= bus.valid_i && taken;
      if (bus.valid_i) begin
        bus.br_target_o <= target;
        bus.pc_o        <= bus.pc_i;
        bus.alu_res_o   <= alu_res;
        bus.rs2_data_o  <= rs2_data;
        bus.rd_o        <= bus.rd_i;
        bus.funct3_o    <= bus.funct3_i;
        bus.regwren_o   <= bus.regwren_i;
        bus.memren_o    <= bus.memren_i;
        bus.memwren_o   <= bus.memwren_i;
        bus.wbsel_o     <= bus.wbsel_i;
      end
    end
endmodule
